i2c_reg_sequencer: RTL

- Hardware Wishbone master that sequences `i2c_master_top` for single-byte register write and register read transactions to one fixed I2C slave.
- Replaces software polling of the TXR/CR/SR registers.
- Sits between a simple command/response interface on the system side and the Wishbone slave port of `i2c_master_top`, which stays at the default clock and uses the same register map.

---
 rtl/i2c_reg_sequencer_if.sv | 36 +++
 rtl/i2c_reg_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer_if.sv
// Bundle of the command/response handshake and the Wishbone master bus
// between the register sequencer and its neighbours.
interface i2c_reg_sequencer_if;
  // command / response side
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       busy;
  // Wishbone side towards i2c_master_top
  logic [2:0] m_adr_o;
  logic [7:0] m_dat_o;
  logic [7:0] m_dat_i;
  logic       m_we_o;
  logic       m_stb_o;
  logic       m_cyc_o;
  logic       m_ack_i;

  // sequencer view
  modport master (
    input  cmd_valid, cmd_rw, cmd_reg, cmd_wdata, m_dat_i, m_ack_i,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           m_adr_o, m_dat_o, m_we_o, m_stb_o, m_cyc_o
  );

  // environment view (command source plus Wishbone slave)
  modport slave (
    output cmd_valid, cmd_rw, cmd_reg, cmd_wdata, m_dat_i, m_ack_i,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           m_adr_o, m_dat_o, m_we_o, m_stb_o, m_cyc_o
  );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Wishbone master that drives i2c_master_top through single-byte register
// write and register read transactions to one fixed I2C slave.
module i2c_reg_sequencer #(
  parameter logic [15:0] PRESCALE   = 16'h003F,
  parameter logic [6:0]  SLAVE_ADDR = 7'h10,
  parameter logic [15:0] POLL_LIMIT = 16'd4096
) (
  input logic wb_clk_i,
  input logic wb_rst_ni,
  i2c_reg_sequencer_if.master bus
);
  localparam logic [2:0] ADR_PRER_LO = 3'd0;
  localparam logic [2:0] ADR_PRER_HI = 3'd1;
  localparam logic [2:0] ADR_CTR     = 3'd2;
  localparam logic [2:0] ADR_TXR     = 3'd3;  // RXR when read
  localparam logic [2:0] ADR_CR      = 3'd4;  // SR when read
  localparam logic [7:0] CR_STOP     = 8'h40;
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_AL      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {WB_IDLE, WB_BUSY, WB_GAP} wb_state_e;
  typedef enum logic [3:0] {
    S_INIT_LO, S_INIT_HI, S_INIT_CTR, S_IDLE, S_TXR, S_CR, S_POLL,
    S_NACK_STOP, S_NACK_POLL, S_TO_STOP, S_RXR, S_RESP
  } state_e;
  typedef enum logic [2:0] {PH_AW, PH_REG, PH_DAT, PH_AR, PH_RD} phase_e;

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  wb_state_e  wb_state_q, wb_state_d;
  logic [15:0] poll_cnt_q, poll_cnt_d, poll_cnt_inc;
  logic       rw_q, rw_d;
  logic [7:0] reg_q, reg_d, wdata_q, wdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0] rsp_err_q, rsp_err_d;
  logic       m_cyc_q, m_cyc_d, m_stb_q, m_stb_d, m_we_q, m_we_d;
  logic [2:0] m_adr_q, m_adr_d;
  logic [7:0] m_dat_q, m_dat_d;
  // request from the main FSM to the shared Wishbone access engine
  logic       wb_req, wb_we, wb_done;
  logic [2:0] wb_adr;
  logic [7:0] wb_dat;
  logic [7:0] txr_byte, cr_byte;

  assign wb_done      = (wb_state_q == WB_BUSY) && bus.m_ack_i;
  assign poll_cnt_inc = poll_cnt_q + 16'd1;

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.m_cyc_o   = m_cyc_q;
  assign bus.m_stb_o   = m_stb_q;
  assign bus.m_we_o    = m_we_q;
  assign bus.m_adr_o   = m_adr_q;
  assign bus.m_dat_o   = m_dat_q;

  // TXR and CR bytes belonging to the current phase
  always_comb begin
    txr_byte = {SLAVE_ADDR, 1'b0};
    cr_byte  = 8'h90;
    case (phase_q)
      PH_AW:   begin txr_byte = {SLAVE_ADDR, 1'b0}; cr_byte = 8'h90; end
      PH_REG:  begin txr_byte = reg_q;              cr_byte = 8'h10; end
      PH_DAT:  begin txr_byte = wdata_q;            cr_byte = 8'h50; end
      PH_AR:   begin txr_byte = {SLAVE_ADDR, 1'b1}; cr_byte = 8'h90; end
      default: begin txr_byte = 8'h00;              cr_byte = 8'h68; end
    endcase
  end

  // shared access engine: one access, cleared on ack, then one idle cycle
  always_comb begin
    wb_state_d = wb_state_q;
    m_cyc_d = m_cyc_q;
    m_stb_d = m_stb_q;
    m_we_d  = m_we_q;
    m_adr_d = m_adr_q;
    m_dat_d = m_dat_q;
    case (wb_state_q)
      WB_IDLE: if (wb_req) begin
        m_cyc_d = 1'b1;
        m_stb_d = 1'b1;
        m_we_d  = wb_we;
        m_adr_d = wb_adr;
        m_dat_d = wb_we ? wb_dat : 8'h00;
        wb_state_d = WB_BUSY;
      end
      WB_BUSY: if (bus.m_ack_i) begin
        m_cyc_d = 1'b0;
        m_stb_d = 1'b0;
        m_we_d  = 1'b0;
        m_adr_d = 3'd0;
        m_dat_d = 8'h00;
        wb_state_d = WB_GAP;
      end
      default: wb_state_d = WB_IDLE;
    endcase
  end

  // transaction sequencing: init, phases, status checks, response
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    poll_cnt_d  = poll_cnt_q;
    rw_d        = rw_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wb_req      = 1'b0;
    wb_we       = 1'b0;
    wb_adr      = 3'd0;
    wb_dat      = 8'h00;
    case (state_q)
      S_INIT_LO: begin
        wb_req = 1'b1; wb_we = 1'b1; wb_adr = ADR_PRER_LO; wb_dat = PRESCALE[7:0];
        if (wb_done) state_d = S_INIT_HI;
      end
      S_INIT_HI: begin
        wb_req = 1'b1; wb_we = 1'b1; wb_adr = ADR_PRER_HI; wb_dat = PRESCALE[15:8];
        if (wb_done) state_d = S_INIT_CTR;
      end
      S_INIT_CTR: begin
        wb_req = 1'b1; wb_we = 1'b1; wb_adr = ADR_CTR; wb_dat = 8'h80;
        if (wb_done) state_d = S_IDLE;
      end
      S_IDLE: if (bus.cmd_valid) begin
        rw_d    = bus.cmd_rw;
        reg_d   = bus.cmd_reg;
        wdata_d = bus.cmd_wdata;
        phase_d = PH_AW;
        state_d = S_TXR;
      end
      S_TXR: begin
        wb_req = 1'b1; wb_we = 1'b1; wb_adr = ADR_TXR; wb_dat = txr_byte;
        if (wb_done) state_d = S_CR;
      end
      S_CR: begin
        wb_req = 1'b1; wb_we = 1'b1; wb_adr = ADR_CR; wb_dat = cr_byte;
        if (wb_done) begin
          poll_cnt_d = 16'd0;
          state_d    = S_POLL;
        end
      end
      S_POLL: begin
        wb_req = 1'b1; wb_adr = ADR_CR;
        if (wb_done) begin
          if (bus.m_dat_i[1]) begin
            // still transferring: count this read, give up at the limit
            poll_cnt_d = poll_cnt_inc;
            if (poll_cnt_inc >= POLL_LIMIT) state_d = S_TO_STOP;
          end else if (bus.m_dat_i[5]) begin
            // lost arbitration: the bus is not ours, so no STOP
            state_d = S_RESP; rsp_valid_d = 1'b1; rsp_err_d = ERR_AL;
          end else if (bus.m_dat_i[7] && (phase_q != PH_RD)) begin
            if (phase_q == PH_DAT) begin
              state_d = S_RESP; rsp_valid_d = 1'b1; rsp_err_d = ERR_NACK;
            end else begin
              state_d = S_NACK_STOP;
            end
          end else begin
            case (phase_q)
              PH_AW:  begin phase_d = PH_REG; state_d = S_TXR; end
              PH_REG: begin phase_d = rw_q ? PH_AR : PH_DAT; state_d = S_TXR; end
              PH_DAT: begin state_d = S_RESP; rsp_valid_d = 1'b1; rsp_err_d = ERR_OK; end
              PH_AR:  begin phase_d = PH_RD; state_d = S_CR; end
              default: state_d = S_RXR;
            endcase
          end
        end
      end
      S_NACK_STOP: begin
        wb_req = 1'b1; wb_we = 1'b1; wb_adr = ADR_CR; wb_dat = CR_STOP;
        if (wb_done) state_d = S_NACK_POLL;
      end
      S_NACK_POLL: begin
        wb_req = 1'b1; wb_adr = ADR_CR;
        if (wb_done && !bus.m_dat_i[6]) begin
          state_d = S_RESP; rsp_valid_d = 1'b1; rsp_err_d = ERR_NACK;
        end
      end
      S_TO_STOP: begin
        wb_req = 1'b1; wb_we = 1'b1; wb_adr = ADR_CR; wb_dat = CR_STOP;
        if (wb_done) begin
          state_d = S_RESP; rsp_valid_d = 1'b1; rsp_err_d = ERR_TIMEOUT;
        end
      end
      S_RXR: begin
        wb_req = 1'b1; wb_adr = ADR_TXR;
        if (wb_done) begin
          rsp_rdata_d = bus.m_dat_i;
          state_d = S_RESP; rsp_valid_d = 1'b1; rsp_err_d = ERR_OK;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_INIT_LO;
    endcase
  end

  // state and output registers; reset abandons any transfer in flight
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= S_INIT_LO;
      phase_q     <= PH_AW;
      wb_state_q  <= WB_IDLE;
      poll_cnt_q  <= 16'd0;
      rw_q        <= 1'b0;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 2'b00;
      m_cyc_q     <= 1'b0;
      m_stb_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_adr_q     <= 3'd0;
      m_dat_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      wb_state_q  <= wb_state_d;
      poll_cnt_q  <= poll_cnt_d;
      rw_q        <= rw_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      m_cyc_q     <= m_cyc_d;
      m_stb_q     <= m_stb_d;
      m_we_q      <= m_we_d;
      m_adr_q     <= m_adr_d;
      m_dat_q     <= m_dat_d;
    end
  end
endmodule
